// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS integer core. One instruction at a time walks through
//   FETCH / DECODE / EXECUTE / WRITEBACK. Supports ADD, SUB, AND, OR, SLT, JR,
//   ADDI, BEQ, BNE, J and the all-zero NOP. Anything else raises a one-cycle
//   illegal pulse and is skipped.
//
//   DATA_W must be at least 18: branch offsets are a 16-bit immediate shifted
//   left by two.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high
//   imem_req      fetch request, high only in FETCH
//   imem_addr     fetch address, always equal to pc
//   imem_ack      fetch complete, sampled only in FETCH
//   imem_rdata    instruction word, valid with imem_ack
//   pc            current program counter
//   result        last value committed to the register file
//   result_valid  one-cycle pulse when a register write commits
//   illegal       one-cycle pulse after an unsupported instruction executes
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | imem_req high, wait for imem_ack, capture IR
// DECODE    | read rs/rt into the A/B operand registers
// EXECUTE   | ALU / branch resolve, PC update, illegal detection
// WRITEBACK | commit ALU result to rd/rt (discarded for r0)

module mips_multicycle_core #(
  parameter int                DATA_W     = 32,
  parameter int                REG_ADDR_W = 5,
  parameter logic [DATA_W-1:0] PC_RESET   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           ir;
  logic [DATA_W-1:0]     a_q, b_q;
  logic [DATA_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] wr_dst_q;
  logic [DATA_W-1:0]     regs [NUM_REGS];

  // Instruction fields
  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [15:0]           imm;
  logic [25:0]           target;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rs     = ir[21 +: REG_ADDR_W];
  assign rt     = ir[16 +: REG_ADDR_W];
  assign rd     = ir[11 +: REG_ADDR_W];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  // Address arithmetic
  logic [DATA_W-1:0] pc_plus4, imm_sext, br_target, pc_jump;
  logic [27:0]       jump_low;

  assign pc_plus4  = pc + PC_STEP;
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign br_target = pc_plus4 + {imm_sext[DATA_W-3:0], 2'b00};
  assign jump_low  = {target, 2'b00};

  // J keeps the upper bits of PC+4 above bit 27; on narrow builds the
  // 28-bit region target is simply truncated to the PC width.
  generate
    if (DATA_W > 28) begin : g_jump_wide
      assign pc_jump = {pc_plus4[DATA_W-1:28], jump_low};
    end else if (DATA_W == 28) begin : g_jump_exact
      assign pc_jump = jump_low;
    end else begin : g_jump_narrow
      assign pc_jump = jump_low[DATA_W-1:0];
    end
  endgenerate

  // Execute-stage decode
  logic [DATA_W-1:0]     alu_res;
  logic [DATA_W-1:0]     pc_nxt;
  logic [REG_ADDR_W-1:0] wr_dst;
  logic                  wr_en;
  logic                  is_illegal;
  logic                  slt_bit;

  assign slt_bit = ($signed(a_q) < $signed(b_q));

  always_comb begin
    alu_res    = '0;
    pc_nxt     = pc_plus4;
    wr_dst     = rt;
    wr_en      = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_dst = rd;
        // opcode 0 with funct 0 is only a NOP when the whole word is zero
        if (ir != 32'h0) begin
          case (funct)
            F_ADD: begin alu_res = a_q + b_q; wr_en = 1'b1; end
            F_SUB: begin alu_res = a_q - b_q; wr_en = 1'b1; end
            F_AND: begin alu_res = a_q & b_q; wr_en = 1'b1; end
            F_OR:  begin alu_res = a_q | b_q; wr_en = 1'b1; end
            F_SLT: begin
              alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
              wr_en   = 1'b1;
            end
            F_JR:    pc_nxt = a_q;
            default: is_illegal = 1'b1;
          endcase
        end
      end
      OP_ADDI: begin alu_res = a_q + imm_sext; wr_en = 1'b1; end
      OP_BEQ:  if (a_q == b_q) pc_nxt = br_target;
      OP_BNE:  if (a_q != b_q) pc_nxt = br_target;
      OP_J:    pc_nxt = pc_jump;
      default: is_illegal = 1'b1;
    endcase
  end

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (imem_ack) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = wr_en ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir           <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_q        <= '0;
      wr_dst_q     <= '0;
      pc           <= PC_RESET;
      result       <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          // r0 is never written, so reading it always yields zero
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        S_EXECUTE: begin
          pc       <= pc_nxt;
          alu_q    <= alu_res;
          wr_dst_q <= wr_dst;
          illegal  <= is_illegal;
        end
        S_WRITEBACK: begin
          if (wr_dst_q != '0) begin
            regs[wr_dst_q] <= alu_q;
            result         <= alu_q;
            result_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset1 = 1'b1;
  logic        reset2 = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        sel = 1'b0;

  logic        req1, valid1, illegal1;
  logic [31:0] addr1, pc1, result1;
  logic        req2, valid2, illegal2;
  logic [17:0] addr2, pc2, result2;

  always #5 clk = ~clk;

  mips_multicycle_core #(.DATA_W(32), .REG_ADDR_W(5), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset1),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc1), .result(result1), .result_valid(valid1), .illegal(illegal1)
  );

  mips_multicycle_core #(.DATA_W(18), .REG_ADDR_W(3), .PC_RESET(18'h0)) dut_narrow (
    .clk(clk), .reset(reset2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc2), .result(result2), .result_valid(valid2), .illegal(illegal2)
  );

  logic        cur_req, cur_valid, cur_illegal;
  logic [31:0] cur_addr, cur_pc, cur_result;

  assign cur_req     = sel ? req2 : req1;
  assign cur_valid   = sel ? valid2 : valid1;
  assign cur_illegal = sel ? illegal2 : illegal1;
  assign cur_addr    = sel ? {14'b0, addr2} : addr1;
  assign cur_pc      = sel ? {14'b0, pc2} : pc1;
  assign cur_result  = sel ? {14'b0, result2} : result1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ill_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard of pending register writes and the cycle they must appear in
  typedef struct {
    logic [31:0] val;
    int          due;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("result", cur_result, e.val);
        chk("result_latency", cyc, e.due);
      end
    end
    if (cur_illegal) begin
      ill_cnt++;
      chk("illegal_with_req", cur_req, 1);
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          waits;
    logic [31:0] pc;
    int          cpi;
    bit          push;
    logic [31:0] res;
  } step_t;
  step_t prog[$];

  task automatic add(input logic [31:0] instr, input logic [31:0] pc, input int cpi,
                     input bit push, input logic [31:0] res, input int waits);
    step_t s;
    s.instr = instr; s.pc = pc; s.cpi = cpi; s.push = push; s.res = res; s.waits = waits;
    prog.push_back(s);
  endtask

  // Fetch handshake for one instruction, then measure cycles to the next fetch.
  task automatic run_instr(input step_t s);
    int t;
    t = 0;
    while (!cur_req && t < 20) begin @(negedge clk); t++; end
    chk("req_seen", cur_req, 1);
    chk("fetch_addr", cur_addr, s.pc);
    chk("pc_port", cur_pc, s.pc);
    for (int w = 0; w < s.waits; w++) begin
      @(negedge clk);
      chk("wait_req", cur_req, 1);
      chk("wait_addr", cur_addr, s.pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = s.instr;
    if (s.push) begin
      sb_t e;
      e.val = s.res;
      e.due = cyc + 4;
      sb.push_back(e);
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    t = 1;
    while (!cur_req && t < 10) begin @(negedge clk); t++; end
    chk("cpi", t, s.cpi);
  endtask

  task automatic run_prog();
    while (prog.size() > 0) run_instr(prog.pop_front());
  endtask

  task automatic check_reset_state();
    #1;
    chk("rst_pc", cur_pc, 0);
    chk("rst_req", cur_req, 1);
    chk("rst_result", cur_result, 0);
    chk("rst_valid", cur_valid, 0);
    chk("rst_illegal", cur_illegal, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset1 = 1'b0;
    check_reset_state();

    // Zero-wait ADDI straight after release, ALU chain, then control flow
    add(enc_i(6'h08, 0, 1, 16'h0005), 32'h00, 4, 1, 32'h5, 0);
    add(enc_i(6'h08, 0, 1, 16'hFFFD), 32'h04, 4, 1, 32'hFFFF_FFFD, 0);
    add(enc_i(6'h08, 0, 2, 16'h0007), 32'h08, 4, 1, 32'h7, 0);
    add(enc_r(2, 1, 3, 6'h22),        32'h0C, 4, 1, 32'd10, 0);
    add(enc_r(1, 2, 4, 6'h2A),        32'h10, 4, 1, 32'h1, 0);
    add(enc_r(2, 1, 4, 6'h2A),        32'h14, 4, 1, 32'h0, 0);
    add(enc_i(6'h08, 0, 1, 16'h0007), 32'h18, 4, 1, 32'h7, 0);
    add(enc_j(26'h4),                 32'h1C, 3, 0, 0, 0);
    add(enc_i(6'h04, 1, 2, 16'h0003), 32'h10, 3, 0, 0, 0);
    add(enc_j(26'h4),                 32'h20, 3, 0, 0, 0);
    add(enc_i(6'h05, 1, 2, 16'h0003), 32'h10, 3, 0, 0, 0);
    add(enc_i(6'h05, 1, 3, 16'hFFFE), 32'h14, 3, 0, 0, 0);
    add(enc_i(6'h04, 1, 3, 16'h0005), 32'h10, 3, 0, 0, 0);
    add(enc_i(6'h08, 0, 5, 16'h0100), 32'h14, 4, 1, 32'h100, 0);
    add(enc_r(5, 0, 0, 6'h08),        32'h18, 3, 0, 0, 0);
    add(enc_j(26'h40),                32'h100, 3, 0, 0, 0);
    add(enc_i(6'h08, 0, 0, 16'h0009), 32'h100, 4, 0, 0, 0);
    add(enc_r(0, 1, 6, 6'h20),        32'h104, 4, 1, 32'h7, 0);
    add(32'hFC00_0000,                32'h108, 3, 0, 0, 0);
    add(enc_r(1, 2, 3, 6'h3F),        32'h10C, 3, 0, 0, 0);
    run_prog();
    @(negedge clk);
    chk("illegal_count", ill_cnt, 2);

    add(enc_r(5, 6, 7, 6'h25),        32'h110, 4, 1, 32'h107, 0);
    add(enc_r(7, 5, 8, 6'h24),        32'h114, 4, 1, 32'h100, 0);
    add(32'h0000_0000,                32'h118, 3, 0, 0, 0);
    add(enc_r(0, 0, 0, 6'h08),        32'h11C, 3, 0, 0, 0);
    add(enc_i(6'h08, 0, 9, 16'h0001), 32'h00, 4, 1, 32'h1, 5);
    run_prog();

    // Reset in the middle of a pending fetch at pc=4, ack arriving during reset
    repeat (2) @(negedge clk);
    chk("midfetch_addr", cur_addr, 32'h4);
    reset1 = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = enc_i(6'h08, 0, 1, 16'h0077);
    @(negedge clk);
    imem_ack = 1'b0;
    reset1   = 1'b0;
    check_reset_state();
    repeat (6) @(negedge clk);
    chk("late_ack_req", cur_req, 1);
    chk("late_ack_pc", cur_pc, 0);
    // Registers were cleared by reset: r1 + r0 must be 0
    add(enc_r(1, 0, 2, 6'h20), 32'h00, 4, 1, 32'h0, 0);
    run_prog();
    repeat (2) @(negedge clk);
    chk("sb_drained_wide", sb.size(), 0);

    // Narrow build: 18-bit datapath, 8 registers
    reset1 = 1'b1;
    sel    = 1'b1;
    @(negedge clk);
    reset2 = 1'b0;
    check_reset_state();
    add(enc_i(6'h08, 0, 1, 16'hFFFF), 32'h00, 4, 1, 32'h3FFFF, 0);
    add(enc_i(6'h08, 1, 2, 16'h0001), 32'h04, 4, 1, 32'h0, 0);
    add(enc_i(6'h08, 1, 9, 16'h0002), 32'h08, 4, 1, 32'h1, 0);
    add(enc_r(1, 0, 3, 6'h20),        32'h0C, 4, 1, 32'h1, 0);
    add(enc_j(26'hFFFF),              32'h10, 3, 0, 0, 0);
    add(32'h0000_0000,                32'h3FFFC, 3, 0, 0, 0);
    add(enc_i(6'h08, 0, 4, 16'h0003), 32'h00, 4, 1, 32'h3, 0);
    run_prog();
    repeat (2) @(negedge clk);
    chk("sb_drained_narrow", sb.size(), 0);
    chk("illegal_total", ill_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
